// File: rtl/konata_id_tracker.sv
// Instruction-ID tracker feeding the Konata pipeline-trace dump model (IF1..WB).
// Optional macro KONATA_ID_CHECK_EN adds a sticky shadow-valid vs. core-valid consistency check.
module konata_id_tracker #(
   parameter int                   ID_WIDTH = 64,
   parameter logic [ID_WIDTH-1:0]  RESET_ID = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if1_valid,
   input  logic                if2_valid,
   input  logic                id_valid,
   input  logic                rr_valid,
   input  logic                exe_valid,
   input  logic                wb_valid,
   input  logic                if1_stall,
   input  logic                if2_stall,
   input  logic                id_stall,
   input  logic                rr_stall,
   input  logic                exe_stall,
   input  logic                if1_flush,
   input  logic                if2_flush,
   input  logic                id_flush,
   input  logic                rr_flush,
   input  logic                exe_flush,
   output logic [ID_WIDTH-1:0] if1_id,
   output logic [ID_WIDTH-1:0] if2_id,
   output logic [ID_WIDTH-1:0] id_id,
   output logic [ID_WIDTH-1:0] rr_id,
   output logic [ID_WIDTH-1:0] exe_id,
   output logic [ID_WIDTH-1:0] wb_id,
   output logic [4:0]          trk_valid,
   output logic [ID_WIDTH-1:0] retire_count,
   output logic                id_check_err,
   output logic [2:0]          id_check_stage
);

   logic [ID_WIDTH-1:0] next_id_reg;
   logic [ID_WIDTH-1:0] retire_count_reg;
   logic [ID_WIDTH-1:0] stage_id_reg  [0:4];
   logic                stage_vld_reg [0:4];
   logic [ID_WIDTH-1:0] up_id         [0:4];

   // Index 0..4 = upstream stage IF1..EXE; downstream index 0..4 = IF2..WB.
   logic [4:0] up_valid;
   logic [4:0] up_stall;
   logic [4:0] up_flush;
   logic [4:0] up_adv;
   logic [4:0] dn_stall;
   logic [4:0] dn_flush;

   assign up_valid = {exe_valid, rr_valid, id_valid, if2_valid, if1_valid};
   assign up_stall = {exe_stall, rr_stall, id_stall, if2_stall, if1_stall};
   assign up_flush = {exe_flush, rr_flush, id_flush, if2_flush, if1_flush};
   assign up_adv   = up_valid & ~up_stall & ~up_flush;
   // WB never stalls or flushes, so it empties whenever EXE does not advance.
   assign dn_stall = {1'b0, exe_stall, rr_stall, id_stall, if2_stall};
   assign dn_flush = {1'b0, exe_flush, rr_flush, id_flush, if2_flush};

   // A killed IF1 instruction still consumes its ID so IDs are never reused.
   always_ff @(posedge clk) begin
      if (rst) begin
         next_id_reg      <= RESET_ID;
         retire_count_reg <= '0;
      end else begin
         if (if1_valid && (!if1_stall || if1_flush))
            next_id_reg <= next_id_reg + ID_WIDTH'(1);
         if (wb_valid)
            retire_count_reg <= retire_count_reg + ID_WIDTH'(1);
      end
   end

   assign up_id[0] = next_id_reg;

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_stage
         if (gi > 0) begin : g_up
            assign up_id[gi] = stage_id_reg[gi-1];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               stage_id_reg[gi]  <= '0;
               stage_vld_reg[gi] <= 1'b0;
            end else if (up_adv[gi]) begin
               stage_id_reg[gi]  <= up_id[gi];
               stage_vld_reg[gi] <= 1'b1;
            end else if (dn_flush[gi] || !dn_stall[gi]) begin
               stage_vld_reg[gi] <= 1'b0;
            end
         end

         assign trk_valid[gi] = stage_vld_reg[gi];
      end
   endgenerate

   assign if1_id       = next_id_reg;
   assign if2_id       = stage_id_reg[0];
   assign id_id        = stage_id_reg[1];
   assign rr_id        = stage_id_reg[2];
   assign exe_id       = stage_id_reg[3];
   assign wb_id        = stage_id_reg[4];
   assign retire_count = retire_count_reg;

`ifdef KONATA_ID_CHECK_EN
   logic [4:0] core_dn_valid;
   logic [4:0] mismatch;
   logic [2:0] mis_code;
   logic [2:0] mis_idx;
   logic       check_err_reg;
   logic [2:0] check_stage_reg;

   assign core_dn_valid = {wb_valid, exe_valid, rr_valid, id_valid, if2_valid};
   assign mismatch      = trk_valid ^ core_dn_valid;

   // Lowest mismatching stage wins; code is stage index + 1 so 0 means none.
   always_comb begin
      mis_code = 3'd0;
      mis_idx  = 3'd0;
      for (int k = 4; k >= 0; k--) begin
         if (mismatch[k]) begin
            mis_code = 3'(k + 1);
            mis_idx  = 3'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         check_err_reg   <= 1'b0;
         check_stage_reg <= 3'd0;
      end else if (!check_err_reg && (mismatch != 5'd0)) begin
         check_err_reg   <= 1'b1;
         check_stage_reg <= mis_code;
`ifndef SYNTHESIS
         $error("konata_id_tracker: valid mismatch at stage %0d, id %0h",
                mis_code, stage_id_reg[mis_idx]);
`endif
      end
   end

   assign id_check_err   = check_err_reg;
   assign id_check_stage = check_stage_reg;
`else
   assign id_check_err   = 1'b0;
   assign id_check_stage = 3'd0;
`endif

endmodule

// File: tb/tb_konata_id_tracker.sv
// Directed, table-driven bench for konata_id_tracker (default build, no consistency check).
module tb_konata_id_tracker;

   localparam logic [63:0] RESET2 = 64'hFFFF_FFFF_FFFF_FFFE;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic if1_valid, if2_valid, id_valid, rr_valid, exe_valid, wb_valid;
   logic if1_stall, if2_stall, id_stall, rr_stall, exe_stall;
   logic if1_flush, if2_flush, id_flush, rr_flush, exe_flush;

   logic [63:0] if1_id, if2_id, id_id, rr_id, exe_id, wb_id, retire_count;
   logic [4:0]  trk_valid;
   logic        id_check_err;
   logic [2:0]  id_check_stage;

   logic [63:0] b_if1_id, b_if2_id, b_id_id, b_rr_id, b_exe_id, b_wb_id, b_retire_count;
   logic [4:0]  b_trk_valid;
   logic        b_id_check_err;
   logic [2:0]  b_id_check_stage;

   konata_id_tracker #(.ID_WIDTH(64), .RESET_ID(64'd0)) dut (
      .clk(clk), .rst(rst),
      .if1_valid(if1_valid), .if2_valid(if2_valid), .id_valid(id_valid),
      .rr_valid(rr_valid), .exe_valid(exe_valid), .wb_valid(wb_valid),
      .if1_stall(if1_stall), .if2_stall(if2_stall), .id_stall(id_stall),
      .rr_stall(rr_stall), .exe_stall(exe_stall),
      .if1_flush(if1_flush), .if2_flush(if2_flush), .id_flush(id_flush),
      .rr_flush(rr_flush), .exe_flush(exe_flush),
      .if1_id(if1_id), .if2_id(if2_id), .id_id(id_id), .rr_id(rr_id),
      .exe_id(exe_id), .wb_id(wb_id), .trk_valid(trk_valid),
      .retire_count(retire_count), .id_check_err(id_check_err),
      .id_check_stage(id_check_stage)
   );

   konata_id_tracker #(.ID_WIDTH(64), .RESET_ID(RESET2)) dut_wrap (
      .clk(clk), .rst(rst),
      .if1_valid(if1_valid), .if2_valid(if2_valid), .id_valid(id_valid),
      .rr_valid(rr_valid), .exe_valid(exe_valid), .wb_valid(wb_valid),
      .if1_stall(if1_stall), .if2_stall(if2_stall), .id_stall(id_stall),
      .rr_stall(rr_stall), .exe_stall(exe_stall),
      .if1_flush(if1_flush), .if2_flush(if2_flush), .id_flush(id_flush),
      .rr_flush(rr_flush), .exe_flush(exe_flush),
      .if1_id(b_if1_id), .if2_id(b_if2_id), .id_id(b_id_id), .rr_id(b_rr_id),
      .exe_id(b_exe_id), .wb_id(b_wb_id), .trk_valid(b_trk_valid),
      .retire_count(b_retire_count), .id_check_err(b_id_check_err),
      .id_check_stage(b_id_check_stage)
   );

   typedef struct {
      logic        rst;
      logic [5:0]  v;     // {wb,exe,rr,id,if2,if1}
      logic [4:0]  st;    // {exe,rr,id,if2,if1}
      logic [4:0]  fl;    // {exe,rr,id,if2,if1}
      logic [63:0] e_if1;
      logic [4:0]  e_trk;
      logic [63:0] e_if2, e_id, e_rr, e_exe, e_wb, e_ret;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   int n_checks = 0;
   int n_errors = 0;

   function automatic vec_t mk(input logic r, input logic [5:0] v, input logic [4:0] st,
                               input logic [4:0] fl, input logic [63:0] if1, input logic [4:0] trk,
                               input logic [63:0] if2, input logic [63:0] idv, input logic [63:0] rr,
                               input logic [63:0] exe, input logic [63:0] wb, input logic [63:0] ret);
      vec_t t;
      t.rst = r; t.v = v; t.st = st; t.fl = fl;
      t.e_if1 = if1; t.e_trk = trk;
      t.e_if2 = if2; t.e_id = idv; t.e_rr = rr; t.e_exe = exe; t.e_wb = wb; t.e_ret = ret;
      return t;
   endfunction

   task automatic chk(input string name, input int step, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [5:0] v, input logic [4:0] st, input logic [4:0] fl);
      rst = r;
      {wb_valid, exe_valid, rr_valid, id_valid, if2_valid, if1_valid} = v;
      {exe_stall, rr_stall, id_stall, if2_stall, if1_stall} = st;
      {exe_flush, rr_flush, id_flush, if2_flush, if1_flush} = fl;
   endtask

   initial begin
      drive(1'b1, 6'b0, 5'b0, 5'b0);

      // Fill: steady stream, 3-cycle front-end stall, 3-stage flush, flush-vs-advance, reset, IF1 stall/flush.
      vecs[0]  = mk(1, 6'b000000, 5'b00000, 5'b00000,  0, 5'b00000,  0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 6'b000001, 5'b00000, 5'b00000,  1, 5'b00001,  0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 6'b000011, 5'b00000, 5'b00000,  2, 5'b00011,  1, 0, 0, 0, 0, 0);
      vecs[3]  = mk(0, 6'b000111, 5'b00000, 5'b00000,  3, 5'b00111,  2, 1, 0, 0, 0, 0);
      vecs[4]  = mk(0, 6'b001111, 5'b00000, 5'b00000,  4, 5'b01111,  3, 2, 1, 0, 0, 0);
      vecs[5]  = mk(0, 6'b011111, 5'b00000, 5'b00000,  5, 5'b11111,  4, 3, 2, 1, 0, 0);
      vecs[6]  = mk(0, 6'b111111, 5'b00000, 5'b00000,  6, 5'b11111,  5, 4, 3, 2, 1, 1);
      vecs[7]  = mk(0, 6'b111111, 5'b00000, 5'b00000,  7, 5'b11111,  6, 5, 4, 3, 2, 2);
      vecs[8]  = mk(0, 6'b111111, 5'b00111, 5'b00000,  7, 5'b11011,  6, 5, 4, 4, 3, 3);
      vecs[9]  = mk(0, 6'b110111, 5'b00111, 5'b00000,  7, 5'b10011,  6, 5, 4, 4, 4, 4);
      vecs[10] = mk(0, 6'b100111, 5'b00111, 5'b00000,  7, 5'b00011,  6, 5, 4, 4, 4, 5);
      vecs[11] = mk(0, 6'b000111, 5'b00000, 5'b00000,  8, 5'b00111,  7, 6, 5, 4, 4, 5);
      vecs[12] = mk(0, 6'b001111, 5'b00000, 5'b00111,  9, 5'b01000,  7, 6, 5, 5, 4, 5);
      vecs[13] = mk(0, 6'b010001, 5'b00000, 5'b00000, 10, 5'b10001,  9, 6, 5, 5, 5, 5);
      vecs[14] = mk(0, 6'b100011, 5'b00000, 5'b00000, 11, 5'b00011, 10, 9, 5, 5, 5, 6);
      vecs[15] = mk(0, 6'b000111, 5'b00010, 5'b00010, 12, 5'b00101, 11, 9, 9, 5, 5, 6);
      vecs[16] = mk(1, 6'b111111, 5'b00000, 5'b00000,  0, 5'b00000,  0, 0, 0, 0, 0, 0);
      vecs[17] = mk(0, 6'b000001, 5'b00001, 5'b00000,  0, 5'b00000,  0, 0, 0, 0, 0, 0);
      vecs[18] = mk(0, 6'b000001, 5'b00001, 5'b00001,  1, 5'b00000,  0, 0, 0, 0, 0, 0);

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].rst, vecs[i].v, vecs[i].st, vecs[i].fl);
         @(posedge clk);
         #1;
         chk("if1_id",         i, if1_id,         vecs[i].e_if1);
         chk("trk_valid",      i, 64'(trk_valid), 64'(vecs[i].e_trk));
         chk("if2_id",         i, if2_id,         vecs[i].e_if2);
         chk("id_id",          i, id_id,          vecs[i].e_id);
         chk("rr_id",          i, rr_id,          vecs[i].e_rr);
         chk("exe_id",         i, exe_id,         vecs[i].e_exe);
         chk("wb_id",          i, wb_id,          vecs[i].e_wb);
         chk("retire_count",   i, retire_count,   vecs[i].e_ret);
         chk("id_check_err",   i, 64'(id_check_err),   64'd0);
         chk("id_check_stage", i, 64'(id_check_stage), 64'd0);
         chk("wrap_if1_id",    i, b_if1_id,       vecs[i].e_if1 + RESET2);
         $display("vec %0d: if1_id=%0d trk=%b wb_id=%0d retire=%0d", i, if1_id, trk_valid, wb_id, retire_count);
      end

      // Wrap sequence: RESET_ID = ...FFFE, all stages valid every cycle.
      drive(1'b1, 6'b0, 5'b0, 5'b0);
      @(posedge clk);
      #1;
      chk("wrap_rst_if1", 100, b_if1_id, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("wrap_rst_ret", 100, b_retire_count, 64'd0);
      $display("wrap reset: if1_id=%0h", b_if1_id);
      for (int k = 1; k <= 7; k++) begin
         drive(1'b0, 6'b111111, 5'b0, 5'b0);
         @(posedge clk);
         #1;
         case (k)
            1: chk("wrap_if1", 100 + k, b_if1_id, 64'hFFFF_FFFF_FFFF_FFFF);
            2: chk("wrap_if1", 100 + k, b_if1_id, 64'h0);
            3: chk("wrap_if1", 100 + k, b_if1_id, 64'h1);
            5: begin
               chk("wrap_wb",  100 + k, b_wb_id, 64'hFFFF_FFFF_FFFF_FFFE);
               chk("wrap_trk", 100 + k, 64'(b_trk_valid), 64'h1F);
               chk("lat_wb",   100 + k, wb_id, 64'd0);
            end
            6: begin
               chk("wrap_wb",  100 + k, b_wb_id, 64'hFFFF_FFFF_FFFF_FFFF);
               chk("lat_wb",   100 + k, wb_id, 64'd1);
            end
            7: begin
               chk("wrap_wb",  100 + k, b_wb_id, 64'h0);
               chk("wrap_ret", 100 + k, b_retire_count, 64'd7);
               chk("lat_ret",  100 + k, retire_count, 64'd7);
            end
            default: chk("lat_if1", 100 + k, if1_id, 64'(k));
         endcase
         $display("wrap cycle %0d: if1_id=%0h wb_id=%0h trk=%b", k, b_if1_id, b_wb_id, b_trk_valid);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
